dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-side responder for the memory queue's dcache request port: accepts one word request (d_addr/d_rmask/d_wmask/d_wdata), returns d_rdata with a one-cycle d_resp pulse.
- Converts word requests into line bursts on the burst memory interface. A read is a line fetch; a write is a read-modify-write of the full line.
- Sits between memory_queue and the memory arbiter/bmem. One request outstanding; no caching unless the optional feature is enabled.

Parameters:
- BEAT_WIDTH, 64, bits per burst beat.
- BURST_BEATS, 4, beats per line; line = 256 bits = 32 bytes; line address = {d_addr[31:5], 5'b0}.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- d_addr  in  32  byte address; [1:0] ignored (word aligned)
- d_rmask  in  4  byte read mask; nonzero = read request
- d_wmask  in  4  byte write mask; nonzero = write request (has priority over d_rmask)
- d_wdata  in  32  write data, byte lanes per d_wmask
- d_rdata  out  32  aligned word read; valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  line address for read/write
- bmem_read  out  1  line read request, 1 cycle
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory can accept a command
- bmem_raddr  in  32  line address of returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values: d_rdata=0, d_resp=0, bmem_addr=0, bmem_read=0, bmem_write=0, bmem_wdata=0. Internal beat counter = 0, state = IDLE.
- FSM states:
  - IDLE: if (d_wmask|d_rmask)!=0, latch the line address, word offset d_addr[4:2], masks and wdata; go to RD_REQ. A request with only d_rmask set is a read; any d_wmask bit set makes it a write.
  - RD_REQ: drive bmem_addr = latched line address. When bmem_ready=1, assert bmem_read for exactly that cycle and go to RD_WAIT. Otherwise hold bmem_read=0 and stay.
  - RD_WAIT: on bmem_rvalid with bmem_raddr equal to the latched line address, store beat[cnt] into line bytes [8*cnt+7:8*cnt] and increment cnt. Ignore beats with mismatched raddr. After beat BURST_BEATS-1, clear cnt and go to RESP for a read, or MERGE for a write.
  - MERGE: overwrite the bytes of the target word selected by wmask with d_wdata lanes; go to WR.
  - WR: wait for bmem_ready=1 at beat 0. Then drive bmem_write=1 with beats 0..3 on 4 consecutive cycles, bmem_addr stable. After beat 3, go to RESP.
  - RESP: d_resp=1 for one cycle; go to IDLE.
- d_rdata:
  - Registered. Loaded in RESP with the selected word of the line; for a write, this is the post-merge word.
  - Holds its value until the next RESP.
- Latency, from the IDLE sample cycle with zero memory latency: read = RD_REQ + 4 beats + RESP. The next request can be sampled the cycle after d_resp.
- Requester contract: hold d_addr/masks/wdata stable until d_resp. The responder samples inputs only in IDLE; changes in other states are ignored.
- Wrap: the word offset selects within the line only; line crossing is impossible because requests are word aligned.
- rst mid-operation:
  - Return to IDLE; no d_resp is issued and the latched request is dropped.
  - Any bmem_write beat in progress is abandoned.
  - Stray bmem_rvalid beats arriving in IDLE are discarded.

Optional Feature:
- DMEM_LINE_BUF_EN defined: add a one-line buffer (valid, tag[31:5], 256-bit data).
  - Read hit in IDLE: go directly to RESP (d_resp the cycle after sampling), with no bmem traffic.
  - Write hit: skip RD_REQ/RD_WAIT and go to MERGE, which updates the buffer too.
  - Every completed fetch or merge loads the buffer.
  - rst clears valid.
- Undefined: no buffer; every request takes the full path above.

Test Plan:
- Read: d_addr=0x0000_1008, d_rmask=4'hF, memory line beats {0x1111_2222_3333_4444, 0x5555_6666_7777_8888, ...} -> bmem_read one pulse with bmem_addr=0x1000, d_rdata=0x7777_8888 (beat1 low word), d_resp one cycle.
- Write: d_addr=0x1004, d_wmask=4'b0011, d_wdata=0xAAAA_BBBB, line beat0=0x1111_2222_3333_4444 -> 4 write beats, beat0=0x1111_BBBB_3333_4444, beats 1-3 unchanged, d_resp, d_rdata=0x1111_BBBB.
- Backpressure: bmem_ready=0 for 5 cycles in RD_REQ -> bmem_read stays 0 until ready, asserts exactly once; same check at the first beat of WR.
- Foreign beats: rvalid beats with raddr=0x2000 interleaved during a 0x1000 fetch -> ignored, result uses only 0x1000 beats.
- Reset mid-write after beat 1 -> bmem_write drops the next cycle, no d_resp, all outputs 0; a new read then completes normally.
- With DMEM_LINE_BUF_EN defined: second read to the same line -> d_resp one cycle after sampling, no bmem_read; a read to a different line -> full fetch.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: turns single-word dcache requests into line bursts (read = fetch, write = read-modify-write).
// Optional DMEM_LINE_BUF_EN keeps the last line as a one-entry buffer so hits skip memory traffic.
module dmem_responder #(
  parameter int BEAT_WIDTH  = 64,
  parameter int BURST_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           d_addr,
  input  logic [3:0]            d_rmask,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);
  localparam int CW = $clog2(BURST_BEATS);
  localparam int LB = BEAT_WIDTH * BURST_BEATS / 8;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, MERGE, WR, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] off;
  logic is_wr;
  logic [3:0] wm;
  logic [31:0] wd;
  logic [BURST_BEATS-1:0][BEAT_WIDTH-1:0] line, lbt;
  logic [LB-1:0][7:0] lby;
  logic [7:0][31:0] lw;
  logic req, hit, beat_ok, last, unused;
  assign unused = ^d_addr[1:0];
  assign req = |(d_wmask | d_rmask);
  assign beat_ok = state == RD_WAIT && bmem_rvalid && bmem_raddr == bmem_addr;
  assign last = cnt == CW'(BURST_BEATS - 1);
  assign bmem_read = state == RD_REQ && bmem_ready;
  assign bmem_write = state == WR && (cnt != '0 || bmem_ready);
  assign bmem_wdata = bmem_write ? line[cnt] : '0;
  // lw is the next line image: incoming beat inserted, then write lanes merged
  always_comb begin
    lbt = line;
    if (beat_ok) lbt[cnt] = bmem_rdata;
    lby = lbt;
    for (int b = 0; b < 4; b++)
      if (state == MERGE && wm[b]) lby[{off, 2'(b)}] = wd[8*b +: 8];
    lw = lby;
  end
`ifdef DMEM_LINE_BUF_EN
  logic valid;
  assign hit = valid && d_addr[31:5] == bmem_addr[31:5];
  always_ff @(posedge clk)
    if (rst) valid <= 1'b0;
    else if (state == IDLE && req && !hit) valid <= 1'b0;
    else if (beat_ok && last) valid <= 1'b1;
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      off <= '0;
      is_wr <= 1'b0;
      wm <= '0;
      wd <= '0;
      line <= '0;
      bmem_addr <= '0;
      d_rdata <= '0;
      d_resp <= 1'b0;
    end else begin
      d_resp <= 1'b0;
      line <= lw;
      case (state)
        IDLE: if (req) begin
          off <= d_addr[4:2];
          is_wr <= |d_wmask;
          wm <= d_wmask;
          wd <= d_wdata;
          bmem_addr <= {d_addr[31:5], 5'b0};
          if (hit && !(|d_wmask)) begin
            state <= RESP;
            d_resp <= 1'b1;
            d_rdata <= lw[d_addr[4:2]];
          end else state <= hit ? MERGE : RD_REQ;
        end
        RD_REQ: if (bmem_ready) state <= RD_WAIT;
        RD_WAIT: if (beat_ok) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            if (is_wr) state <= MERGE;
            else begin
              state <= RESP;
              d_resp <= 1'b1;
              d_rdata <= lw[off];
            end
          end
        end
        MERGE: state <= WR;
        WR: if (bmem_write) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            state <= RESP;
            d_resp <= 1'b1;
            d_rdata <= lw[off];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
